slc3_stim_sequencer: RTL and testbench
======================================

// Module: slc3_stim_sequencer
// PURPOSE
//  Synthesizable, parametrised stimulus/check sequencer for the SLC-3 top level. Plays a
//  loadable script that drives SW, Run and Continue, waits on fixed delays or on the CPU
//  pause indication, and compares observed CPU outputs against expected values. Replaces
//  hand-timed bench stimulus; usable in simulation and on the board in front of slc3_testtop.
// PARAMETERS
//  SW_W        10   width of driven switch bus
//  DATA_W      16   instruction operand width; also observed-value width (>= SW_W)
//  DEPTH       32   script entries (power of two)
//  PULSE_CYC   2    cycles a Run/Continue pulse stays asserted (>= 1)
//  CNT_W       8    width of err_cnt / pass_cnt
//  TIMEOUT     1024 WAITP timeout in cycles (used only with SEQ_TIMEOUT_EN)
// PORTS
//  Clk        in   1                 system clock, all logic rising-edge
//  Reset      in   1                 synchronous, active-high
//  prog_we    in   1                 script write strobe (honoured only when busy=0)
//  prog_addr  in   $clog2(DEPTH)     script write address
//  prog_data  in   4+DATA_W          {opcode[3:0], operand[DATA_W-1:0]}
//  start      in   1                 1-cycle request to run script from entry 0
//  pause_i    in   1                 CPU waiting for Continue (level)
//  obs_i      in   DATA_W            observed CPU value (e.g. decoded HEX / PC)
//  SW         out  SW_W              driven switches
//  Run        out  1                 active-high Run pulse
//  Continue   out  1                 active-high Continue pulse
//  busy       out  1                 script executing
//  done       out  1                 script finished; held until next start
//  err_cnt    out  CNT_W             failed CHECKs + illegal opcodes + timeouts
//  pass_cnt   out  CNT_W             passed CHECKs
//  pc         out  $clog2(DEPTH)     current entry index
// BEHAVIOUR
//  Opcodes: 0 END, 1 SETSW (SW<=operand[SW_W-1:0]), 2 RUN (pulse Run), 3 CONT (pulse Continue),
//   4 WAIT (operand idle cycles), 5 WAITP (wait for pause_i=1), 6 CHECK (obs_i==operand),
//   7-15 illegal: err_cnt+1, skip.
//  Reset: SW=0, Run=0, Continue=0, busy=0, done=0, err_cnt=0, pass_cnt=0, pc=0, state IDLE.
//   Script memory is NOT reset; contents survive Reset.
//  States: IDLE -> FETCH -> EXEC -> {PULSE | WAIT | WAITP} -> FETCH ...; END -> DONE.
//  Memory read is synchronous: FETCH issues address pc, EXEC sees the entry next cycle.
//  Latency: SETSW/CHECK/illegal = 2 cycles; RUN/CONT = 2+PULSE_CYC; WAIT n = 2+n (n=0 -> 2);
//   WAITP = 2 + cycles until pause_i high (pause_i already high -> 2).
//  IDLE/DONE + start: pc<=0, counters cleared, done<=0, busy<=1, SW held at last value.
//  start while busy: ignored. prog_we while busy: ignored (write dropped).
//  CHECK: obs_i sampled in EXEC; match -> pass_cnt+1, else err_cnt+1. Both saturate at all-ones.
//  pc increments after each executed entry; last entry (DEPTH-1) executed without END ->
//   implicit END, err_cnt+1 (overrun), no wrap to 0.
//  DONE: busy=0, done=1, outputs hold; Run/Continue always 0 outside PULSE.
//  Reset mid-script: immediate return to reset values next edge; any pulse truncated.
//  Simultaneous start and prog_we in IDLE: write completes first-priority, script starts
//   same cycle; FETCH of entry 0 sees the new data if prog_addr=0.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined: WAITP aborts after TIMEOUT cycles without pause_i,
//   err_cnt+1, continue with next entry.
//  SEQ_TIMEOUT_EN undefined: WAITP waits indefinitely; TIMEOUT unused, no counter built.
// TESTING
//  1 Load {SETSW 0x031, RUN, WAIT 100, SETSW 0x002, CONT, END}, start -> SW=0x031, Run high
//    exactly 2 cycles, SW=0x002 after 100 idle cycles, Continue 2 cycles, done=1, err_cnt=0.
//  2 Script {WAITP, CHECK 0x0003, CHECK 0x0004, END}, pause_i after 50 cycles, obs_i=3 ->
//    WAITP releases 1 cycle after pause_i, pass_cnt=1, err_cnt=1.
//  3 Script of DEPTH entries of SETSW only, no END -> stops at pc=DEPTH-1, done=1, err_cnt=1.
//  4 Reset asserted mid-PULSE of CONT -> Continue=0, busy=0, counters 0 next edge;
//    re-start replays unchanged script.
//  5 SEQ_TIMEOUT_EN, WAITP with pause_i=0 -> after 1024 cycles err_cnt=1, next entry runs;
//    without macro, busy stays 1 for 5000 cycles.
//  6 prog_we and start pulses while busy -> ignored; 300 CHECK mismatches -> err_cnt=255.

Source files
------------

// File: rtl/slc3_stim_sequencer.sv
// slc3_stim_sequencer
// Script-driven stimulus/check sequencer placed in front of the SLC-3 top level.
// A small script memory holds {opcode[3:0], operand[DATA_W-1:0]} entries. When started,
// the script is played from entry 0. It drives SW, pulses Run/Continue, waits on a cycle
// count or on the CPU pause level, and compares the observed CPU value against expected
// operands. Passed and failed checks are counted in saturating counters.
//
// Opcodes: 0 END, 1 SETSW, 2 RUN, 3 CONT, 4 WAIT n, 5 WAITP, 6 CHECK, 7-15 illegal (counted, skipped)
//
// Ports
//   Clk, Reset        rising-edge clock, synchronous active-high reset
//   prog_we/addr/data script write port, only honoured while not busy
//   start             one-cycle request to play the script from entry 0
//   pause_i           CPU is waiting for Continue (level)
//   obs_i             observed CPU value compared by CHECK
//   SW, Run, Continue driven CPU stimulus
//   busy, done        script executing / script finished (held until next start)
//   err_cnt, pass_cnt failed checks + illegal opcodes + overruns (+ timeouts) / passed checks
//   pc                current script entry
//
// Build option: define SEQ_TIMEOUT_EN to make WAITP give up after TIMEOUT cycles
// (counted as an error). Without it WAITP waits indefinitely.

module slc3_stim_sequencer #(
    parameter int SW_W      = 10,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 32,
    parameter int PULSE_CYC = 2,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [4+DATA_W-1:0]      prog_data,
    input  logic                     start,
    input  logic                     pause_i,
    input  logic [DATA_W-1:0]        obs_i,
    output logic [SW_W-1:0]          SW,
    output logic                     Run,
    output logic                     Continue,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [$clog2(DEPTH)-1:0] pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = 4 + DATA_W;

    localparam logic [3:0] OP_END   = 4'd0;
    localparam logic [3:0] OP_SETSW = 4'd1;
    localparam logic [3:0] OP_RUN   = 4'd2;
    localparam logic [3:0] OP_CONT  = 4'd3;
    localparam logic [3:0] OP_WAIT  = 4'd4;
    localparam logic [3:0] OP_WAITP = 4'd5;
    localparam logic [3:0] OP_CHECK = 4'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_PULSE, S_WAIT, S_WAITP, S_DONE
    } state_t;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       n);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(n);
        if (s[CNT_W]) return '1;
        return s[CNT_W-1:0];
    endfunction

    state_t             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [SW_W-1:0]    sw_q, sw_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic [DATA_W-1:0]  cnt_q, cnt_d;
    logic               is_cont_q, is_cont_d;
    logic [IW-1:0]      ir_q;
    logic [IW-1:0]      mem [DEPTH];

    logic [3:0]         op;
    logic [DATA_W-1:0]  operand;
    logic               advance;
    logic [1:0]         err_inc;
    logic [1:0]         pass_inc;

`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]   tmo_q, tmo_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign op      = ir_q[IW-1 -: 4];
    assign operand = ir_q[DATA_W-1:0];

    // Script memory: not reset, so a loaded script survives Reset. The entry is
    // latched only in FETCH so the instruction stays stable across PULSE/WAIT.
    always_ff @(posedge Clk) begin
        if (prog_we && !busy) mem[prog_addr] <= prog_data;
        if (state_q == S_FETCH) ir_q <= mem[pc_q];
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sw_d      = sw_q;
        err_d     = err_q;
        pass_d    = pass_q;
        cnt_d     = cnt_q;
        is_cont_d = is_cont_q;
        advance   = 1'b0;
        err_inc   = 2'd0;
        pass_inc  = 2'd0;
`ifdef SEQ_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    err_d   = '0;
                    pass_d  = '0;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_END:   state_d = S_DONE;
                    OP_SETSW: begin
                        sw_d    = operand[SW_W-1:0];
                        advance = 1'b1;
                    end
                    OP_RUN, OP_CONT: begin
                        is_cont_d = (op == OP_CONT);
                        cnt_d     = DATA_W'(PULSE_CYC - 1);
                        state_d   = S_PULSE;
                    end
                    OP_WAIT: begin
                        if (operand == '0) begin
                            advance = 1'b1;
                        end else begin
                            cnt_d   = operand - DATA_W'(1);
                            state_d = S_WAIT;
                        end
                    end
                    OP_WAITP: begin
`ifdef SEQ_TIMEOUT_EN
                        tmo_d = '0;
`endif
                        if (pause_i) advance = 1'b1;
                        else         state_d = S_WAITP;
                    end
                    OP_CHECK: begin
                        if (obs_i == operand) pass_inc = 2'd1;
                        else                  err_inc  = 2'd1;
                        advance = 1'b1;
                    end
                    default: begin
                        err_inc = 2'd1;
                        advance = 1'b1;
                    end
                endcase
            end
            S_PULSE, S_WAIT: begin
                // cnt_q holds remaining cycles minus one in this state
                if (cnt_q == '0) advance = 1'b1;
                else             cnt_d   = cnt_q - DATA_W'(1);
            end
            S_WAITP: begin
                if (pause_i) advance = 1'b1;
`ifdef SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_inc = err_inc + 2'd1;
                    advance = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Completing the last entry without END is an overrun: stop there, no wrap.
        if (advance) begin
            if (pc_q == AW'(DEPTH - 1)) begin
                state_d = S_DONE;
                err_inc = err_inc + 2'd1;
            end else begin
                pc_d    = pc_q + AW'(1);
                state_d = S_FETCH;
            end
        end

        err_d  = sat_add(err_d, err_inc);
        pass_d = sat_add(pass_d, pass_inc);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            sw_q      <= '0;
            err_q     <= '0;
            pass_q    <= '0;
            is_cont_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sw_q      <= sw_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            is_cont_q <= is_cont_d;
        end
        cnt_q <= cnt_d;
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge Clk) begin
        if (Reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`endif

    assign SW       = sw_q;
    assign Run      = (state_q == S_PULSE) && !is_cont_q;
    assign Continue = (state_q == S_PULSE) &&  is_cont_q;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign err_cnt  = err_q;
    assign pass_cnt = pass_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_slc3_stim_sequencer.sv
module tb_slc3_stim_sequencer;

    localparam int SW_W    = 10;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 512;
    localparam int PULSE   = 2;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 1024;
    localparam int AW      = $clog2(DEPTH);

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              prog_we = 1'b0;
    logic [AW-1:0]     prog_addr = '0;
    logic [19:0]       prog_data = '0;
    logic              start = 1'b0;
    logic              pause_i = 1'b0;
    logic [15:0]       obs_i = '0;
    logic [SW_W-1:0]   SW;
    logic              Run, Continue, busy, done;
    logic [CNT_W-1:0]  err_cnt, pass_cnt;
    logic [AW-1:0]     pc;

    slc3_stim_sequencer #(
        .SW_W(SW_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PULSE_CYC(PULSE),
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .pause_i(pause_i), .obs_i(obs_i),
        .SW(SW), .Run(Run), .Continue(Continue), .busy(busy), .done(done),
        .err_cnt(err_cnt), .pass_cnt(pass_cnt), .pc(pc)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // Image of the script memory as the bench last loaded it.
    logic [19:0] scr [DEPTH];
    // Expected {SW, Run, Continue} after each clock edge, starting with the start edge.
    logic [11:0] exp_q [$];
    int          exp_err, exp_pass, exp_pc;
    logic [9:0]  exp_sw;
    logic [9:0]  cur_sw;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [19:0] enc(input logic [3:0] op, input logic [15:0] opd);
        return {op, opd};
    endfunction

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            prog_we   = 1'b1;
            prog_addr = AW'(i);
            prog_data = scr[i];
            tick();
        end
        prog_we = 1'b0;
    endtask

    // Interpret the script with the documented per-opcode cycle costs: every entry
    // costs fetch+exec (2 cycles) plus PULSE cycles for RUN/CONT or n for WAIT n.
    // WAITP is assumed to find pause_i already high.
    function automatic void model(input logic [9:0] init_sw, input logic [15:0] obs);
        logic [9:0]  sw;
        logic [3:0]  op;
        logic [15:0] opd;
        int          e, p, idx;
        bit          fin;
        sw = init_sw; e = 0; p = 0; idx = 0; fin = 1'b0;
        exp_q.delete();
        while (!fin) begin
            op  = scr[idx][19:16];
            opd = scr[idx][15:0];
            exp_q.push_back({sw, 2'b00});
            exp_q.push_back({sw, 2'b00});
            case (op)
                4'd0: fin = 1'b1;
                4'd1: sw = opd[9:0];
                4'd2: for (int k = 0; k < PULSE; k++) exp_q.push_back({sw, 2'b10});
                4'd3: for (int k = 0; k < PULSE; k++) exp_q.push_back({sw, 2'b01});
                4'd4: for (int k = 0; k < int'(opd); k++) exp_q.push_back({sw, 2'b00});
                4'd5: ;
                4'd6: if (obs == opd) p++; else e++;
                default: e++;
            endcase
            if (!fin) begin
                if (idx == DEPTH - 1) begin
                    e++;
                    fin = 1'b1;
                end else begin
                    idx++;
                end
            end
        end
        exp_err  = (e > 255) ? 255 : e;
        exp_pass = (p > 255) ? 255 : p;
        exp_pc   = idx;
        exp_sw   = sw;
    endfunction

    // Starts the script (optionally writing entry 0 in the same cycle) and runs until
    // done or the cycle bound; counts pulse cycles and trace deviations from exp_q.
    task automatic run_script(input int bound, input bit chk, input bit wr0,
                              input logic [19:0] wdat,
                              output int cyc, output int runs, output int conts,
                              output int bad);
        cyc = 0; runs = 0; conts = 0; bad = 0;
        start = 1'b1;
        if (wr0) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = wdat;
        end
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        if (chk && exp_q.size() > 0 && {SW, Run, Continue} !== exp_q[0]) bad++;
        while (done !== 1'b1 && cyc < bound) begin
            tick();
            cyc++;
            if (Run)      runs++;
            if (Continue) conts++;
            if (chk) begin
                if (cyc < exp_q.size()) begin
                    if ({SW, Run, Continue} !== exp_q[cyc]) bad++;
                end else if (done !== 1'b1) begin
                    bad++;
                end
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        cur_sw = '0;
        checks++; if (SW !== 10'h0)      begin failures++; $display("FAIL reset_sw got=%h exp=0", SW); end
        checks++; if (Run !== 1'b0)      begin failures++; $display("FAIL reset_run got=%b exp=0", Run); end
        checks++; if (Continue !== 1'b0) begin failures++; $display("FAIL reset_cont got=%b exp=0", Continue); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err_cnt !== 8'd0)  begin failures++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
        checks++; if (pass_cnt !== 8'd0) begin failures++; $display("FAIL reset_pass got=%0d exp=0", pass_cnt); end
        checks++; if (pc !== '0)         begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    endtask

    task automatic test_basic();
        int cyc, runs, conts, bad;
        scr[0] = enc(4'd1, 16'h0031);
        scr[1] = enc(4'd2, 16'h0000);
        scr[2] = enc(4'd4, 16'd100);
        scr[3] = enc(4'd1, 16'h0002);
        scr[4] = enc(4'd3, 16'h0000);
        scr[5] = enc(4'd0, 16'h0000);
        load(6);
        model(cur_sw, obs_i);
        run_script(400, 1'b1, 1'b0, 20'h0, cyc, runs, conts, bad);
        cur_sw = 10'h002;
        checks++; if (cyc !== 116)       begin failures++; $display("FAIL basic_cycles got=%0d exp=116", cyc); end
        checks++; if (bad !== 0)         begin failures++; $display("FAIL basic_trace bad_cycles=%0d exp=0", bad); end
        checks++; if (runs !== 2)        begin failures++; $display("FAIL basic_run_len got=%0d exp=2", runs); end
        checks++; if (conts !== 2)       begin failures++; $display("FAIL basic_cont_len got=%0d exp=2", conts); end
        checks++; if (SW !== 10'h002)    begin failures++; $display("FAIL basic_sw got=%h exp=002", SW); end
        checks++; if (done !== 1'b1)     begin failures++; $display("FAIL basic_done got=%b exp=1", done); end
        checks++; if (err_cnt !== 8'd0)  begin failures++; $display("FAIL basic_err got=%0d exp=0", err_cnt); end
        checks++; if (pc !== AW'(5))     begin failures++; $display("FAIL basic_pc got=%0d exp=5", pc); end
    endtask

    task automatic test_waitp();
        int cyc;
        scr[0] = enc(4'd5, 16'h0000);
        scr[1] = enc(4'd6, 16'h0003);
        scr[2] = enc(4'd6, 16'h0004);
        scr[3] = enc(4'd0, 16'h0000);
        load(4);
        obs_i   = 16'h0003;
        pause_i = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (50) tick();
        checks++; if (pc !== '0 || busy !== 1'b1) begin
            failures++; $display("FAIL waitp_held pc=%0d busy=%b exp pc=0 busy=1", pc, busy);
        end
        pause_i = 1'b1;
        tick();
        checks++; if (pc !== AW'(1)) begin failures++; $display("FAIL waitp_release pc=%0d exp=1", pc); end
        cyc = 0;
        while (done !== 1'b1 && cyc < 50) begin tick(); cyc++; end
        pause_i = 1'b0;
        checks++; if (cyc !== 6)         begin failures++; $display("FAIL waitp_tail got=%0d exp=6", cyc); end
        checks++; if (pass_cnt !== 8'd1) begin failures++; $display("FAIL waitp_pass got=%0d exp=1", pass_cnt); end
        checks++; if (err_cnt !== 8'd1)  begin failures++; $display("FAIL waitp_err got=%0d exp=1", err_cnt); end
        checks++; if (pc !== AW'(3))     begin failures++; $display("FAIL waitp_pc got=%0d exp=3", pc); end
    endtask

    task automatic test_overrun();
        int cyc, runs, conts, bad;
        for (int i = 0; i < DEPTH; i++) scr[i] = enc(4'd1, 16'($urandom_range(0, 1023)));
        load(DEPTH);
        model(cur_sw, obs_i);
        run_script(3000, 1'b1, 1'b0, 20'h0, cyc, runs, conts, bad);
        cur_sw = exp_sw;
        checks++; if (cyc !== 2 * DEPTH)     begin failures++; $display("FAIL ovr_cycles got=%0d exp=%0d", cyc, 2 * DEPTH); end
        checks++; if (bad !== 0)             begin failures++; $display("FAIL ovr_trace bad_cycles=%0d exp=0", bad); end
        checks++; if (pc !== AW'(DEPTH - 1)) begin failures++; $display("FAIL ovr_pc got=%0d exp=%0d", pc, DEPTH - 1); end
        checks++; if (err_cnt !== 8'd1)      begin failures++; $display("FAIL ovr_err got=%0d exp=1", err_cnt); end
        checks++; if (done !== 1'b1)         begin failures++; $display("FAIL ovr_done got=%b exp=1", done); end
        checks++; if (SW !== exp_sw)         begin failures++; $display("FAIL ovr_sw got=%h exp=%h", SW, exp_sw); end
    endtask

    task automatic test_reset_mid();
        int cyc, runs, conts, bad, w;
        scr[0] = enc(4'd6, 16'hBEEF);
        scr[1] = enc(4'd1, 16'h0155);
        scr[2] = enc(4'd3, 16'h0000);
        scr[3] = enc(4'd0, 16'h0000);
        load(4);
        obs_i = 16'h0000;
        start = 1'b1; tick(); start = 1'b0;
        w = 0;
        while (Continue !== 1'b1 && w < 30) begin tick(); w++; end
        checks++; if (Continue !== 1'b1 || err_cnt !== 8'd1) begin
            failures++; $display("FAIL rmid_pre cont=%b err=%0d exp cont=1 err=1", Continue, err_cnt);
        end
        Reset = 1'b1;
        tick();
        checks++; if (Continue !== 1'b0) begin failures++; $display("FAIL rmid_cont got=%b exp=0", Continue); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL rmid_state busy=%b done=%b exp 0 0", busy, done);
        end
        checks++; if (err_cnt !== 8'd0 || pass_cnt !== 8'd0 || pc !== '0 || SW !== 10'h0) begin
            failures++; $display("FAIL rmid_regs err=%0d pass=%0d pc=%0d sw=%h exp all 0", err_cnt, pass_cnt, pc, SW);
        end
        Reset = 1'b0;
        tick();
        cur_sw = '0;
        model(cur_sw, obs_i);
        run_script(100, 1'b1, 1'b0, 20'h0, cyc, runs, conts, bad);
        cur_sw = exp_sw;
        checks++; if (bad !== 0 || cyc !== exp_q.size()) begin
            failures++; $display("FAIL rmid_replay bad=%0d cyc=%0d exp bad=0 cyc=%0d", bad, cyc, exp_q.size());
        end
        checks++; if (conts !== PULSE || err_cnt !== 8'd1) begin
            failures++; $display("FAIL rmid_replay_out conts=%0d err=%0d exp %0d 1", conts, err_cnt, PULSE);
        end
    endtask

    task automatic test_timeout();
        scr[0] = enc(4'd5, 16'h0000);
        scr[1] = enc(4'd1, 16'h03AA);
        scr[2] = enc(4'd0, 16'h0000);
        load(3);
        pause_i = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        begin
            int cyc, runs, conts, bad;
            run_script(3000, 1'b0, 1'b0, 20'h0, cyc, runs, conts, bad);
            cur_sw = 10'h3AA;
            checks++; if (cyc !== 2 + TIMEOUT + 4) begin
                failures++; $display("FAIL tmo_cycles got=%0d exp=%0d", cyc, 2 + TIMEOUT + 4);
            end
            checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL tmo_err got=%0d exp=1", err_cnt); end
            checks++; if (SW !== 10'h3AA)   begin failures++; $display("FAIL tmo_next got=%h exp=3aa", SW); end
        end
`else
        start = 1'b1; tick(); start = 1'b0;
        repeat (5000) tick();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL waitp_forever busy=%b done=%b exp 1 0", busy, done);
        end
        checks++; if (pc !== '0 || err_cnt !== 8'd0) begin
            failures++; $display("FAIL waitp_forever_regs pc=%0d err=%0d exp 0 0", pc, err_cnt);
        end
        Reset = 1'b1; tick(); Reset = 1'b0; tick();
        cur_sw = '0;
`endif
    endtask

    task automatic test_busy_ignore();
        int cyc;
        for (int i = 0; i < 300; i++) scr[i] = enc(4'd6, 16'hFFFF);
        scr[300] = enc(4'd0, 16'h0000);
        load(301);
        obs_i = 16'h0000;
        model(cur_sw, obs_i);
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            start     = (cyc == 10);
            prog_we   = (cyc == 20);
            prog_addr = AW'(100);
            prog_data = 20'h0;
            tick();
            cyc++;
        end
        start = 1'b0; prog_we = 1'b0;
        checks++; if (cyc !== 602 || cyc !== exp_q.size()) begin
            failures++; $display("FAIL busy_ign_cycles got=%0d exp=602", cyc);
        end
        checks++; if (err_cnt !== 8'd255 || exp_err != 255) begin
            failures++; $display("FAIL sat_err got=%0d exp=255", err_cnt);
        end
        checks++; if (pass_cnt !== 8'd0 || pc !== AW'(300)) begin
            failures++; $display("FAIL busy_ign_regs pass=%0d pc=%0d exp 0 300", pass_cnt, pc);
        end
    endtask

    task automatic test_start_write();
        int cyc, runs, conts, bad;
        scr[0] = enc(4'd0, 16'h0000);
        scr[1] = enc(4'd0, 16'h0000);
        load(2);
        scr[0] = enc(4'd1, 16'h00AB);
        model(cur_sw, obs_i);
        run_script(50, 1'b1, 1'b1, scr[0], cyc, runs, conts, bad);
        cur_sw = exp_sw;
        checks++; if (SW !== 10'h0AB || cyc !== 4) begin
            failures++; $display("FAIL start_write sw=%h cyc=%0d exp 0ab 4", SW, cyc);
        end
        checks++; if (bad !== 0 || pc !== AW'(1)) begin
            failures++; $display("FAIL start_write_trace bad=%0d pc=%0d exp 0 1", bad, pc);
        end
    endtask

    task automatic test_random();
        int cyc, runs, conts, bad, n, r;
        logic [15:0] obs;
        pause_i = 1'b1;
        for (int it = 0; it < 6; it++) begin
            n   = $urandom_range(1, 25);
            obs = 16'($urandom);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 9: scr[i] = enc(4'd1, 16'($urandom));
                    1:    scr[i] = enc(4'd2, 16'($urandom));
                    2:    scr[i] = enc(4'd3, 16'($urandom));
                    3:    scr[i] = enc(4'd4, 16'($urandom_range(0, 6)));
                    4:    scr[i] = enc(4'd5, 16'($urandom));
                    5:    scr[i] = enc(4'd6, obs);
                    6:    scr[i] = enc(4'd6, 16'($urandom));
                    default: scr[i] = enc(4'($urandom_range(7, 15)), 16'($urandom));
                endcase
            end
            scr[n] = enc(4'd0, 16'($urandom));
            load(n + 1);
            obs_i = obs;
            model(cur_sw, obs);
            run_script(1000, 1'b1, 1'b0, 20'h0, cyc, runs, conts, bad);
            cur_sw = exp_sw;
            checks++; if (bad !== 0 || cyc !== exp_q.size()) begin
                failures++; $display("FAIL rand%0d_trace bad=%0d cyc=%0d exp bad=0 cyc=%0d", it, bad, cyc, exp_q.size());
            end
            checks++; if (err_cnt !== 8'(exp_err) || pass_cnt !== 8'(exp_pass)) begin
                failures++; $display("FAIL rand%0d_cnt err=%0d pass=%0d exp %0d %0d", it, err_cnt, pass_cnt, exp_err, exp_pass);
            end
            checks++; if (pc !== AW'(exp_pc) || SW !== exp_sw || done !== 1'b1) begin
                failures++; $display("FAIL rand%0d_end pc=%0d sw=%h done=%b exp %0d %h 1", it, pc, SW, done, exp_pc, exp_sw);
            end
        end
        pause_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_waitp();
        test_overrun();
        test_reset_mid();
        test_timeout();
        test_busy_ignore();
        test_start_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
